r_burst_sender: RTL and testbench
=================================

# r_burst_sender

Serializes whole-burst read-response records, popped from the burst FIFO's head, onto an AXI4 R channel one beat per handshake. It is the consumer end of the response FIFO: it captures one stored burst (ID, RRESP, beat count, flattened payload), pops the entry, then streams `nbeats` RDATA beats with RLAST on the final beat. Malformed entries (request records, zero or oversize beat counts) are popped and discarded with an error strobe.

## Interface
Parameters:
- `DATA_WIDTH`, 64, width of one RDATA beat.
- `MAX_BEATS`, 32, max beats per burst; payload width is `MAX_BEATS*DATA_WIDTH`.
- Derived: `NB_W = $clog2(MAX_BEATS+1)`, `IDX_W = (MAX_BEATS<=2) ? 1 : $clog2(MAX_BEATS)`.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `fifo_empty`  in  1  FIFO has no entry.
- `fifo_rd_en`  out  1  pop strobe to FIFO (one cycle per entry).
- `head_kind`  in  1  0 = request, 1 = response.
- `head_id`  in  8  RID to drive.
- `head_len`  in  8  ARLEN echoed in record.
- `head_rresp`  in  2  RRESP for every beat.
- `head_nbeats`  in  NB_W  beats in burst.
- `head_payload`  in  MAX_BEATS*DATA_WIDTH  beat k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `head_tag`  in  8  internal UID.
- `rvalid`  out  1  AXI R valid.
- `rready`  in  1  AXI R ready.
- `rid`  out  8  AXI RID.
- `rdata`  out  DATA_WIDTH  AXI RDATA.
- `rresp`  out  2  AXI RRESP.
- `rlast`  out  1  AXI RLAST.
- `burst_done`  out  1  one-cycle pulse after final beat accepted.
- `done_tag`  out  8  tag of burst completed/dropped; valid with `burst_done`/`drop_err`.
- `drop_err`  out  1  one-cycle pulse when an entry is discarded.
- `busy`  out  1  high in SEND.

## Operation
- FSM states: IDLE, SEND.
- IDLE: if `!fifo_empty`, assert `fifo_rd_en` combinationally that cycle; capture id, rresp, nbeats, payload, tag into local registers; clear `beat_idx` to 0.
  - Valid entry (`head_kind==1`, `1 <= head_nbeats <= MAX_BEATS`) -> SEND next cycle.
  - Otherwise -> stay IDLE; `drop_err`=1 and `done_tag`=head_tag next cycle.
- SEND: `rvalid`=1; `rdata` = captured beat[`beat_idx`]; `rid`/`rresp` = captured values; `rlast` = (`beat_idx == nbeats-1`).
  - On `rvalid & rready`: if `rlast` -> IDLE, `burst_done`=1 next cycle; else `beat_idx` += 1.
  - No handshake: all R outputs held stable (AXI rule: valid never drops before accept).
- `fifo_rd_en` never asserted in SEND; never asserted while `fifo_empty`.
- Capture uses the FIFO's combinational head, so popped data is latched the same edge as the pop.
- Beat count compare uses NB_W width; `beat_idx` zero-extended; no wrap possible since `nbeats <= MAX_BEATS`.

## Timing
- Reset (`rst_n`=0 at edge): state IDLE, `beat_idx`=0, `rvalid`=0, `rlast`=0, `rid`=0, `rdata`=0, `rresp`=0, `burst_done`=0, `drop_err`=0, `done_tag`=0, `busy`=0; `fifo_rd_en`=0 while reset asserted. Reset mid-burst aborts it; remaining beats lost, no `burst_done`.
- Latency: entry at head in cycle N (IDLE) -> pop in N -> first beat `rvalid` in N+1.
- Burst of B beats with `rready` held high occupies B SEND cycles; one IDLE bubble between bursts (next pop at cycle after last accept), so throughput = B/(B+1).
- `rready` low stalls indefinitely; `rready` asserted before `rvalid` is legal and ignored in IDLE.
- Drop: pop in N, `drop_err` in N+1, next pop possible in N+1.

## Configuration
- `RSEND_LEN_CHECK_EN`: when defined, an entry with `head_nbeats != head_len + 1` (9-bit compare) is also dropped with `drop_err`. When undefined, `head_len` is ignored and `head_nbeats` alone sets the beat count.

## Test plan
- Single beat: push id=0x3A, rresp=0, nbeats=1, beat0=0xDEAD_BEEF, rready=1 -> pop N, `rvalid`/`rlast`=1 with rdata=0xDEAD_BEEF at N+1, `burst_done` N+2, `done_tag` matches.
- 4-beat burst, rready toggled 1,0,0,1,1,0,1 -> beats 0..3 in order, outputs stable through stalls, `rlast` only on beat 3, rresp=2'b10 on every beat.
- Back-to-back 32-beat bursts, rready=1 -> 32 beats, one bubble, second burst starts; beat 31 = payload top slice.
- Bad entries: kind=0; nbeats=0; nbeats=33 -> each popped, `drop_err` pulse, `rvalid` never rises; with `RSEND_LEN_CHECK_EN`, nbeats=4/len=2 dropped, nbeats=4/len=3 sent.
- `rst_n` low at beat 2 of 8 -> next cycle `rvalid`=0, state IDLE; after release next FIFO entry sent from beat 0.
- Empty FIFO for 20 cycles -> `fifo_rd_en`, `rvalid`, strobes stay 0.

Source files
------------

// File: rtl/r_burst_sender_if.sv
// r_burst_sender_if
//
// Purpose: AXI4 read-data (R) channel bundle between a burst sender and
// the downstream R-channel consumer.
//
// Signals:
//   rvalid  1           beat valid (master -> slave)
//   rready  1           beat ready (slave -> master)
//   rid     8           RID
//   rdata   DATA_WIDTH  RDATA
//   rresp   2           RRESP
//   rlast   1           RLAST, final beat of the burst
//
// Modports: master (drives the channel), slave (accepts beats).

interface r_burst_sender_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  rvalid;
    logic                  rready;
    logic [7:0]            rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

    modport slave (
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );
endinterface

// File: rtl/r_burst_sender.sv
// r_burst_sender
//
// Purpose: pops whole-burst read-response records from the head of the
// response FIFO and serializes them onto an AXI4 R channel, one beat per
// handshake, with RLAST on the final beat. Request records and entries with
// a zero or oversize beat count are popped and discarded with drop_err.
//
// Optional feature (macro RSEND_LEN_CHECK_EN): when defined, an entry whose
// head_nbeats differs from head_len + 1 is also discarded. When undefined,
// head_len is ignored.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   synchronous active-low reset
//   fifo_empty     in   FIFO has no entry
//   fifo_rd_en     out  pop strobe, one cycle per entry
//   head_kind      in   0 = request record, 1 = response record
//   head_id        in   RID to drive
//   head_len       in   ARLEN echoed in record
//   head_rresp     in   RRESP for every beat
//   head_nbeats    in   beats in burst (NB_W bits)
//   head_payload   in   flattened beats, beat k at [k*DATA_WIDTH +: DATA_WIDTH]
//   head_tag       in   internal UID
//   r              R channel, master modport
//   burst_done     out  pulse the cycle after the final beat is accepted
//   done_tag       out  tag of the completed/dropped burst
//   drop_err       out  pulse the cycle after an entry is discarded
//   busy           out  high while streaming a burst

module r_burst_sender #(
    parameter  int DATA_WIDTH = 64,
    parameter  int MAX_BEATS  = 32,
    localparam int NB_W       = $clog2(MAX_BEATS + 1),
    localparam int IDX_W      = (MAX_BEATS <= 2) ? 1 : $clog2(MAX_BEATS)
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic                            fifo_empty,
    output logic                            fifo_rd_en,
    input  logic                            head_kind,
    input  logic [7:0]                      head_id,
    input  logic [7:0]                      head_len,
    input  logic [1:0]                      head_rresp,
    input  logic [NB_W-1:0]                 head_nbeats,
    input  logic [MAX_BEATS*DATA_WIDTH-1:0] head_payload,
    input  logic [7:0]                      head_tag,

    r_burst_sender_if.master                r,

    output logic                            burst_done,
    output logic [7:0]                      done_tag,
    output logic                            drop_err,
    output logic                            busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]                          beat_idx;
    logic [7:0]                                id_q;
    logic [1:0]                                rresp_q;
    logic [NB_W-1:0]                           nbeats_q;
    logic [7:0]                                tag_q;
    logic [MAX_BEATS-1:0][DATA_WIDTH-1:0]      payload_q;

    logic nbeats_ok;
    logic entry_ok;
    logic is_last;
    logic beat_accept;

    // Beat count must be 1..MAX_BEATS; compared at NB_W width.
    assign nbeats_ok = (head_nbeats != '0) && (head_nbeats <= NB_W'(MAX_BEATS));

`ifdef RSEND_LEN_CHECK_EN
    // Width wide enough for both ARLEN+1 (9 bits) and the beat count.
    localparam int CMP_W = (NB_W > 9) ? NB_W : 9;
    logic len_ok;
    assign len_ok   = (CMP_W'(head_nbeats) == (CMP_W'(head_len) + CMP_W'(1)));
    assign entry_ok = head_kind & nbeats_ok & len_ok;
`else
    logic unused_len;
    assign unused_len = ^head_len;
    assign entry_ok   = head_kind & nbeats_ok;
`endif

    // beat_idx is zero-extended; nbeats_q >= 1 whenever this matters (SEND).
    assign is_last     = (NB_W'(beat_idx) == (nbeats_q - NB_W'(1)));
    assign beat_accept = r.rvalid & r.rready;

    // R payload fields come straight from the captured record so they stay
    // stable across stalls without extra holding registers.
    assign r.rid   = id_q;
    assign r.rresp = rresp_q;
    assign r.rdata = payload_q[beat_idx];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. The pop is gated by rst_n so the
    // FIFO is never popped while reset is held.
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        r.rvalid   = 1'b0;
        r.rlast    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && !fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    if (entry_ok) begin
                        state_next = SEND;
                    end
                end
            end
            SEND: begin
                r.rvalid = 1'b1;
                r.rlast  = is_last;
                busy     = 1'b1;
                if (r.rready && is_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Record capture, beat counter and completion strobes. The capture uses
    // the FIFO's combinational head, latched on the same edge as the pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_idx   <= '0;
            id_q       <= '0;
            rresp_q    <= '0;
            nbeats_q   <= '0;
            tag_q      <= '0;
            payload_q  <= '0;
            burst_done <= 1'b0;
            drop_err   <= 1'b0;
            done_tag   <= '0;
        end else begin
            burst_done <= 1'b0;
            drop_err   <= 1'b0;
            if (fifo_rd_en) begin
                id_q      <= head_id;
                rresp_q   <= head_rresp;
                nbeats_q  <= head_nbeats;
                tag_q     <= head_tag;
                payload_q <= head_payload;
                beat_idx  <= '0;
                if (!entry_ok) begin
                    drop_err <= 1'b1;
                    done_tag <= head_tag;
                end
            end else if (beat_accept) begin
                if (is_last) begin
                    burst_done <= 1'b1;
                    done_tag   <= tag_q;
                end else begin
                    beat_idx <= beat_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_r_burst_sender.sv
// tb_r_burst_sender
//
// Purpose: directed self-checking bench for r_burst_sender. A queue models
// the response FIFO (head shown combinationally, popped on fifo_rd_en).
// Inputs change 1-2 ns after the rising edge; outputs are checked on the
// falling edge. Defining RSEND_LEN_CHECK_EN also enables the length-check
// vectors.

module tb_r_burst_sender;

    localparam int DATA_WIDTH = 64;
    localparam int MAX_BEATS  = 32;
    localparam int NB_W       = $clog2(MAX_BEATS + 1);
    localparam int PW         = MAX_BEATS * DATA_WIDTH;

    typedef struct {
        logic            kind;
        logic [7:0]      id;
        logic [7:0]      len;
        logic [1:0]      rresp;
        logic [NB_W-1:0] nbeats;
        logic [PW-1:0]   payload;
        logic [7:0]      tag;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            fifo_empty;
    logic            fifo_rd_en;
    logic            head_kind;
    logic [7:0]      head_id;
    logic [7:0]      head_len;
    logic [1:0]      head_rresp;
    logic [NB_W-1:0] head_nbeats;
    logic [PW-1:0]   head_payload;
    logic [7:0]      head_tag;
    logic            burst_done;
    logic [7:0]      done_tag;
    logic            drop_err;
    logic            busy;

    entry_t fifo_q[$];
    logic   pop_seen = 1'b0;
    int     errors   = 0;
    int     checks   = 0;

    r_burst_sender_if #(.DATA_WIDTH(DATA_WIDTH)) rif ();

    r_burst_sender #(
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .head_kind   (head_kind),
        .head_id     (head_id),
        .head_len    (head_len),
        .head_rresp  (head_rresp),
        .head_nbeats (head_nbeats),
        .head_payload(head_payload),
        .head_tag    (head_tag),
        .r           (rif.master),
        .burst_done  (burst_done),
        .done_tag    (done_tag),
        .drop_err    (drop_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Present the queue front as the FIFO head.
    function automatic void refreshHead();
        fifo_empty = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) begin
            head_kind    = fifo_q[0].kind;
            head_id      = fifo_q[0].id;
            head_len     = fifo_q[0].len;
            head_rresp   = fifo_q[0].rresp;
            head_nbeats  = fifo_q[0].nbeats;
            head_payload = fifo_q[0].payload;
            head_tag     = fifo_q[0].tag;
        end else begin
            head_kind    = 1'b0;
            head_id      = '0;
            head_len     = '0;
            head_rresp   = '0;
            head_nbeats  = '0;
            head_payload = '0;
            head_tag     = '0;
        end
    endfunction

    // Pop strobe is sampled mid-cycle and applied just after the edge so
    // the head never changes before the DUT has latched it.
    always @(negedge clk) pop_seen = fifo_rd_en;

    always @(posedge clk) begin
        #1;
        if (pop_seen && fifo_q.size() != 0) begin
            fifo_q.pop_front();
        end
        refreshHead();
    end

    // Beat k of a test payload is base + k.
    function automatic logic [PW-1:0] mkPayload(input logic [63:0] base, input int n);
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < n; k++) begin
            p[k*DATA_WIDTH +: DATA_WIDTH] = base + 64'(k);
        end
        return p;
    endfunction

    // Push one record into the FIFO model.
    task automatic applyStimulus(input logic kind, input logic [7:0] id, input logic [7:0] len,
                                 input logic [1:0] rresp, input logic [NB_W-1:0] nbeats,
                                 input logic [PW-1:0] payload, input logic [7:0] tag);
        entry_t e;
        e.kind    = kind;
        e.id      = id;
        e.len     = len;
        e.rresp   = rresp;
        e.nbeats  = nbeats;
        e.payload = payload;
        e.tag     = tag;
        fifo_q.push_back(e);
        refreshHead();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nextDrive();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [PW-1:0] pa;
        logic [PW-1:0] pb;
        logic [63:0]   top_slice;
        logic [6:0]    pat;
        int            exp_idx;

        rst_n       = 1'b0;
        rif.rready  = 1'b0;
        refreshHead();

        // Reset state.
        repeat (3) nextDrive();
        @(negedge clk);
        checkOutput("rst_rvalid",   64'(rif.rvalid), 64'd0);
        checkOutput("rst_rlast",    64'(rif.rlast),  64'd0);
        checkOutput("rst_rid",      64'(rif.rid),    64'd0);
        checkOutput("rst_rdata",    rif.rdata,       64'd0);
        checkOutput("rst_rresp",    64'(rif.rresp),  64'd0);
        checkOutput("rst_done",     64'(burst_done), 64'd0);
        checkOutput("rst_drop",     64'(drop_err),   64'd0);
        checkOutput("rst_done_tag", 64'(done_tag),   64'd0);
        checkOutput("rst_busy",     64'(busy),       64'd0);

        // An entry waiting while reset is held must not be popped.
        applyStimulus(1'b1, 8'h01, 8'h00, 2'b00, NB_W'(1), mkPayload(64'h1, 1), 8'h01);
        @(negedge clk);
        checkOutput("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        fifo_q.delete();
        refreshHead();
        nextDrive();
        rst_n = 1'b1;

        // Single-beat burst.
        nextDrive();
        rif.rready = 1'b1;
        applyStimulus(1'b1, 8'h3A, 8'h00, 2'b00, NB_W'(1), mkPayload(64'hDEAD_BEEF, 1), 8'h11);
        @(negedge clk);
        checkOutput("b1_rd_en",   64'(fifo_rd_en), 64'd1);
        checkOutput("b1_rvalid0", 64'(rif.rvalid), 64'd0);
        @(negedge clk);
        checkOutput("b1_rvalid",  64'(rif.rvalid), 64'd1);
        checkOutput("b1_rlast",   64'(rif.rlast),  64'd1);
        checkOutput("b1_rdata",   rif.rdata,       64'hDEAD_BEEF);
        checkOutput("b1_rid",     64'(rif.rid),    64'h3A);
        checkOutput("b1_busy",    64'(busy),       64'd1);
        checkOutput("b1_no_pop",  64'(fifo_rd_en), 64'd0);
        @(negedge clk);
        checkOutput("b1_done",     64'(burst_done), 64'd1);
        checkOutput("b1_done_tag", 64'(done_tag),   64'h11);
        checkOutput("b1_rvalid_off", 64'(rif.rvalid), 64'd0);
        @(negedge clk);
        checkOutput("b1_done_pulse", 64'(burst_done), 64'd0);

        // Four-beat burst with stalls; rready pattern 1,0,0,1,1,0,1.
        nextDrive();
        applyStimulus(1'b1, 8'h42, 8'h03, 2'b10, NB_W'(4), mkPayload(64'h1000, 4), 8'h22);
        @(negedge clk);
        checkOutput("b4_rd_en", 64'(fifo_rd_en), 64'd1);
        pat     = 7'b1011001;
        exp_idx = 0;
        for (int i = 0; i < 7; i++) begin
            nextDrive();
            rif.rready = pat[i];
            @(negedge clk);
            checkOutput("b4_rvalid", 64'(rif.rvalid), 64'd1);
            checkOutput("b4_rdata",  rif.rdata,       64'h1000 + 64'(exp_idx));
            checkOutput("b4_rlast",  64'(rif.rlast),  64'(exp_idx == 3));
            checkOutput("b4_rresp",  64'(rif.rresp),  64'd2);
            checkOutput("b4_rid",    64'(rif.rid),    64'h42);
            if (pat[i]) exp_idx++;
        end
        @(negedge clk);
        checkOutput("b4_done",     64'(burst_done), 64'd1);
        checkOutput("b4_done_tag", 64'(done_tag),   64'h22);

        // Back-to-back 32-beat bursts, rready held high.
        nextDrive();
        rif.rready = 1'b1;
        pa = mkPayload(64'hA000_0000_0000_0000, 32);
        pb = mkPayload(64'hB000_0000_0000_0100, 32);
        top_slice = pa[PW-1 -: DATA_WIDTH];
        applyStimulus(1'b1, 8'h01, 8'd31, 2'b01, NB_W'(32), pa, 8'h33);
        applyStimulus(1'b1, 8'h02, 8'd31, 2'b00, NB_W'(32), pb, 8'h44);
        @(negedge clk);
        checkOutput("b32_rd_en", 64'(fifo_rd_en), 64'd1);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            checkOutput("b32a_rdata", rif.rdata,      64'hA000_0000_0000_0000 + 64'(k));
            checkOutput("b32a_rlast", 64'(rif.rlast), 64'(k == 31));
        end
        checkOutput("b32a_top_slice", rif.rdata, top_slice);
        @(negedge clk);
        checkOutput("b32_bubble_done",  64'(burst_done), 64'd1);
        checkOutput("b32_bubble_tag",   64'(done_tag),   64'h33);
        checkOutput("b32_bubble_pop",   64'(fifo_rd_en), 64'd1);
        checkOutput("b32_bubble_valid", 64'(rif.rvalid), 64'd0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            checkOutput("b32b_rdata", rif.rdata,      64'hB000_0000_0000_0100 + 64'(k));
            checkOutput("b32b_rid",   64'(rif.rid),   64'h02);
        end
        @(negedge clk);
        checkOutput("b32b_done", 64'(burst_done), 64'd1);
        checkOutput("b32b_tag",  64'(done_tag),   64'h44);

        // Malformed entries: request record, zero beats, 33 beats.
        nextDrive();
        applyStimulus(1'b0, 8'h05, 8'h01, 2'b00, NB_W'(2),  mkPayload(64'h5, 2),  8'hD1);
        applyStimulus(1'b1, 8'h06, 8'hFF, 2'b00, NB_W'(0),  mkPayload(64'h6, 1),  8'hD2);
        applyStimulus(1'b1, 8'h07, 8'd32, 2'b00, NB_W'(33), mkPayload(64'h7, 32), 8'hD3);
        @(negedge clk);
        checkOutput("drop_rd_en0", 64'(fifo_rd_en), 64'd1);
        checkOutput("drop_rvalid0", 64'(rif.rvalid), 64'd0);
        @(negedge clk);
        checkOutput("drop_err_kind", 64'(drop_err),   64'd1);
        checkOutput("drop_tag_kind", 64'(done_tag),   64'hD1);
        checkOutput("drop_rd_en1",   64'(fifo_rd_en), 64'd1);
        checkOutput("drop_rvalid1",  64'(rif.rvalid), 64'd0);
        @(negedge clk);
        checkOutput("drop_err_zero", 64'(drop_err),   64'd1);
        checkOutput("drop_tag_zero", 64'(done_tag),   64'hD2);
        checkOutput("drop_rvalid2",  64'(rif.rvalid), 64'd0);
        @(negedge clk);
        checkOutput("drop_err_big",  64'(drop_err),   64'd1);
        checkOutput("drop_tag_big",  64'(done_tag),   64'hD3);
        checkOutput("drop_rd_en3",   64'(fifo_rd_en), 64'd0);
        checkOutput("drop_rvalid3",  64'(rif.rvalid), 64'd0);
        @(negedge clk);
        checkOutput("drop_pulse",    64'(drop_err),   64'd0);

`ifdef RSEND_LEN_CHECK_EN
        // Length check: nbeats=4/len=2 dropped, nbeats=4/len=3 sent.
        nextDrive();
        applyStimulus(1'b1, 8'h08, 8'd2, 2'b00, NB_W'(4), mkPayload(64'h800, 4), 8'h77);
        applyStimulus(1'b1, 8'h09, 8'd3, 2'b00, NB_W'(4), mkPayload(64'h900, 4), 8'h88);
        @(negedge clk);
        checkOutput("len_rd_en", 64'(fifo_rd_en), 64'd1);
        @(negedge clk);
        checkOutput("len_drop",     64'(drop_err), 64'd1);
        checkOutput("len_drop_tag", 64'(done_tag), 64'h77);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("len_rdata", rif.rdata, 64'h900 + 64'(k));
        end
        @(negedge clk);
        checkOutput("len_done",     64'(burst_done), 64'd1);
        checkOutput("len_done_tag", 64'(done_tag),   64'h88);
`endif

        // Reset during beat 2 of an 8-beat burst.
        nextDrive();
        applyStimulus(1'b1, 8'h55, 8'd7, 2'b00, NB_W'(8), mkPayload(64'h5500, 8), 8'h55);
        @(negedge clk);
        checkOutput("rb_rd_en", 64'(fifo_rd_en), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("rb_beat2", rif.rdata, 64'h5502);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rb_rvalid", 64'(rif.rvalid), 64'd0);
        checkOutput("rb_busy",   64'(busy),       64'd0);
        checkOutput("rb_done",   64'(burst_done), 64'd0);
        nextDrive();
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h66, 8'd7, 2'b11, NB_W'(8), mkPayload(64'h6600, 8), 8'h66);
        @(negedge clk);
        checkOutput("rb_new_pop", 64'(fifo_rd_en), 64'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("rb_new_rdata", rif.rdata, 64'h6600 + 64'(k));
        end
        @(negedge clk);
        checkOutput("rb_new_done", 64'(burst_done), 64'd1);
        checkOutput("rb_new_tag",  64'(done_tag),   64'h66);

        // Empty FIFO: nothing moves, rready high is ignored.
        nextDrive();
        rif.rready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("idle_quiet", 64'({fifo_rd_en, rif.rvalid, burst_done, drop_err}), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
